// File: rtl/x_corr_peak_pkg.sv
// Shared widths, helpers and FSM encoding for the cross-correlation peak tracker.
package x_corr_peak_pkg;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

    function automatic int unsigned mag_width(input int unsigned pw);
        return 2 * pw;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StDrain   = 2'd1,
        StOutput  = 2'd2
    } state_e;

endpackage

// File: rtl/x_corr_peak_cmplx_mag_pipe.sv
// Five-stage complex product and exact |p|^2 pipeline with a valid/index sideband.
module x_corr_peak_cmplx_mag_pipe
    import x_corr_peak_pkg::*;
#(
    parameter int unsigned data_bits  = 12,
    parameter int unsigned index_bits = 4,
    parameter bit          conj_y     = 1'b1,
    parameter int unsigned prod_bits  = prod_width(data_bits),
    parameter int unsigned mag_bits   = mag_width(prod_bits)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [index_bits-1:0]        in_index,
    input  logic signed [data_bits-1:0]  xi,
    input  logic signed [data_bits-1:0]  xq,
    input  logic signed [data_bits-1:0]  yi,
    input  logic signed [data_bits-1:0]  yq,
    output logic                         out_valid,
    output logic [index_bits-1:0]        out_index,
    output logic [mag_bits-1:0]          out_mag,
    output logic signed [prod_bits-1:0]  out_i,
    output logic signed [prod_bits-1:0]  out_q
);

    localparam int unsigned pp_bits = 2 * data_bits;

    logic [4:0]            vld_q;
    logic [index_bits-1:0] idx_q [5];

    // S1
    logic signed [data_bits-1:0] xi_q, xq_q, yi_q, yq_q;
    // S2
    logic signed [pp_bits-1:0] xi_w, xq_w, yi_w, yq_w;
    logic signed [pp_bits-1:0] ii_q, qq_q, qi_q, iq_q;
    // S3
    logic signed [prod_bits-1:0] ii_x, qq_x, qi_x, iq_x;
    logic signed [prod_bits-1:0] pi_d, pq_d, pi3_q, pq3_q;
    // S4
    logic signed [mag_bits-1:0]  pi_w, pq_w;
    logic signed [mag_bits-1:0]  sqi_q, sqq_q;
    logic signed [prod_bits-1:0] pi4_q, pq4_q;
    // S5
    logic [mag_bits-1:0]         mag_q;
    logic signed [prod_bits-1:0] pi5_q, pq5_q;

    // Operands are widened before multiplying so no product is computed at a narrow width.
    always_comb begin
        xi_w = {{data_bits{xi_q[data_bits-1]}}, xi_q};
        xq_w = {{data_bits{xq_q[data_bits-1]}}, xq_q};
        yi_w = {{data_bits{yi_q[data_bits-1]}}, yi_q};
        yq_w = {{data_bits{yq_q[data_bits-1]}}, yq_q};
    end

    always_comb begin
        ii_x = {{(prod_bits-pp_bits){ii_q[pp_bits-1]}}, ii_q};
        qq_x = {{(prod_bits-pp_bits){qq_q[pp_bits-1]}}, qq_q};
        qi_x = {{(prod_bits-pp_bits){qi_q[pp_bits-1]}}, qi_q};
        iq_x = {{(prod_bits-pp_bits){iq_q[pp_bits-1]}}, iq_q};
        if (conj_y) begin
            pi_d = ii_x + qq_x;
            pq_d = qi_x - iq_x;
        end else begin
            pi_d = ii_x - qq_x;
            pq_d = qi_x + iq_x;
        end
    end

    always_comb begin
        pi_w = {{(mag_bits-prod_bits){pi3_q[prod_bits-1]}}, pi3_q};
        pq_w = {{(mag_bits-prod_bits){pq3_q[prod_bits-1]}}, pq3_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[3:0], in_valid};
        end
        idx_q[0] <= in_index;
        for (int s = 1; s < 5; s++) idx_q[s] <= idx_q[s-1];

        xi_q <= xi;
        xq_q <= xq;
        yi_q <= yi;
        yq_q <= yq;

        ii_q <= xi_w * yi_w;
        qq_q <= xq_w * yq_w;
        qi_q <= xq_w * yi_w;
        iq_q <= xi_w * yq_w;

        pi3_q <= pi_d;
        pq3_q <= pq_d;

        sqi_q <= pi_w * pi_w;
        sqq_q <= pq_w * pq_w;
        pi4_q <= pi3_q;
        pq4_q <= pq3_q;

        mag_q <= $unsigned(sqi_q + sqq_q);
        pi5_q <= pi4_q;
        pq5_q <= pq4_q;
    end

    assign out_valid = vld_q[4];
    assign out_index = idx_q[4];
    assign out_mag   = mag_q;
    assign out_i     = pi5_q;
    assign out_q     = pq5_q;

endmodule

// File: rtl/x_corr_peak.sv
// Per-frame streaming cross-correlation peak tracker with threshold detect.
module x_corr_peak
    import x_corr_peak_pkg::*;
#(
    parameter int unsigned data_bits  = 12,
    parameter int unsigned length     = 16,
    parameter int unsigned index_bits = clog2(length),
    parameter bit          conj_y     = 1'b1,
    parameter int unsigned prod_bits  = prod_width(data_bits),
    parameter int unsigned mag_bits   = mag_width(prod_bits)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [data_bits-1:0]  xi,
    input  logic signed [data_bits-1:0]  xq,
    input  logic signed [data_bits-1:0]  yi,
    input  logic signed [data_bits-1:0]  yq,
    input  logic                         m_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [mag_bits-1:0]          threshold,
    input  logic                         m_axis_tready,
    output logic                         s_axis_tvalid,
    output logic [mag_bits-1:0]          out_max,
    output logic [index_bits-1:0]        index,
    output logic signed [prod_bits-1:0]  peak_i,
    output logic signed [prod_bits-1:0]  peak_q,
    output logic                         peak_detect
);

    localparam logic [index_bits-1:0] last_idx = index_bits'(length - 1);

    state_e                      state_q, state_d;
    logic [index_bits-1:0]       cnt_q, cnt_d;
    logic [mag_bits-1:0]         thr_q, thr_d;
    logic [mag_bits-1:0]         max_q, max_d;
    logic [index_bits-1:0]       idx_q, idx_d;
    logic signed [prod_bits-1:0] pi_q, pi_d, pq_q, pq_d;
    logic                        det_q, det_d;

    logic                        accept;
    logic                        pv;
    logic [index_bits-1:0]       pidx;
    logic [mag_bits-1:0]         pmag;
    logic signed [prod_bits-1:0] ppi, ppq;

    assign s_axis_tready = (state_q == StCollect) && !reset;
    assign s_axis_tvalid = (state_q == StOutput);
    assign accept        = m_axis_tvalid && s_axis_tready;

    x_corr_peak_cmplx_mag_pipe #(
        .data_bits  (data_bits),
        .index_bits (index_bits),
        .conj_y     (conj_y),
        .prod_bits  (prod_bits),
        .mag_bits   (mag_bits)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_index  (cnt_q),
        .xi        (xi),
        .xq        (xq),
        .yi        (yi),
        .yq        (yq),
        .out_valid (pv),
        .out_index (pidx),
        .out_mag   (pmag),
        .out_i     (ppi),
        .out_q     (ppq)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        max_d   = max_q;
        idx_d   = idx_q;
        pi_d    = pi_q;
        pq_d    = pq_q;
        det_d   = det_q;

        if (accept && cnt_q == '0) thr_d = threshold;

        // Strict compare keeps the earliest index on ties; sample 0 seeds the frame.
        if (pv && (pidx == '0 || pmag > max_q)) begin
            max_d = pmag;
            idx_d = pidx;
            pi_d  = ppi;
            pq_d  = ppq;
        end

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_q + index_bits'(1);
                    end
                end
            end
            StDrain: begin
                if (pv && pidx == last_idx) begin
                    state_d = StOutput;
                    det_d   = (max_d >= thr_q);
                end
            end
            StOutput: begin
                if (m_axis_tready) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                    max_d   = '0;
                    idx_d   = '0;
                    pi_d    = '0;
                    pq_d    = '0;
                    det_d   = 1'b0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCollect;
            cnt_q   <= '0;
            thr_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            pi_q    <= '0;
            pq_q    <= '0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            pi_q    <= pi_d;
            pq_q    <= pq_d;
            det_q   <= det_d;
        end
    end

    assign out_max     = max_q;
    assign index       = idx_q;
    assign peak_i      = pi_q;
    assign peak_q      = pq_q;
    assign peak_detect = det_q;

endmodule

// File: tb/tb_x_corr_peak.sv
// Scoreboard bench: two instances (conj and non-conj) share stimulus; a monitor checks results.
module tb_x_corr_peak;

    localparam int LEN = 8;
    localparam int DB  = 12;
    localparam int IB  = 3;
    localparam int PB  = 25;
    localparam int MB  = 50;

    logic clk = 1'b0;
    logic reset;
    logic signed [DB-1:0] xi, xq, yi, yq;
    logic m_axis_tvalid, m_axis_tready;
    logic [MB-1:0] threshold;

    logic tready_c1, tvalid_c1, det_c1, tready_c0, tvalid_c0, det_c0;
    logic [MB-1:0] max_c1, max_c0;
    logic [IB-1:0] idx_c1, idx_c0;
    logic signed [PB-1:0] pi_c1, pq_c1, pi_c0, pq_c0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    x_corr_peak #(.data_bits(DB), .length(LEN), .index_bits(IB), .conj_y(1'b1)) dut_c1 (
        .clk(clk), .reset(reset), .xi(xi), .xq(xq), .yi(yi), .yq(yq),
        .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(tready_c1), .threshold(threshold),
        .m_axis_tready(m_axis_tready), .s_axis_tvalid(tvalid_c1), .out_max(max_c1),
        .index(idx_c1), .peak_i(pi_c1), .peak_q(pq_c1), .peak_detect(det_c1)
    );

    x_corr_peak #(.data_bits(DB), .length(LEN), .index_bits(IB), .conj_y(1'b0)) dut_c0 (
        .clk(clk), .reset(reset), .xi(xi), .xq(xq), .yi(yi), .yq(yq),
        .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(tready_c0), .threshold(threshold),
        .m_axis_tready(m_axis_tready), .s_axis_tvalid(tvalid_c0), .out_max(max_c0),
        .index(idx_c0), .peak_i(pi_c0), .peak_q(pq_c0), .peak_detect(det_c0)
    );

    typedef struct {
        longint m1, m0;
        int     i1, i0;
        longint pi1, pq1, pi0, pq0;
        bit     d1, d0;
        int     vcyc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   fxi[LEN], fxq[LEN], fyi[LEN], fyq[LEN];
    int   hold_left = 0;
    bit   seen = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain complex multiply per sample, first-occurrence maximum of |p|^2.
    function automatic void model(input bit conj, input longint thr, output longint m,
                                  output int ix, output longint pi, output longint pq,
                                  output bit d);
        longint ci, cq, a, yqe;
        m = 0; ix = 0; pi = 0; pq = 0;
        for (int k = 0; k < LEN; k++) begin
            yqe = conj ? -longint'(fyq[k]) : longint'(fyq[k]);
            ci  = longint'(fxi[k]) * fyi[k] - longint'(fxq[k]) * yqe;
            cq  = longint'(fxi[k]) * yqe + longint'(fxq[k]) * fyi[k];
            a   = ci * ci + cq * cq;
            if (k == 0 || a > m) begin
                m = a; ix = k; pi = ci; pq = cq;
            end
        end
        d = (m >= thr);
    endfunction

    task automatic fill(input int a, input int b, input int c, input int e);
        for (int k = 0; k < LEN; k++) begin
            fxi[k] = a; fxq[k] = b; fyi[k] = c; fyq[k] = e;
        end
    endtask

    task automatic case_a();
        fill(100, 0, 100, 0);
        fyi[5] = 200;
    endtask

    // mode 0: gap-free, 1: valid toggles every cycle, 2: random gaps
    task automatic send_frame(input longint thr0, input longint thr_mid, input int mode,
                              input int n);
        int i = 0;
        int t_last = 0;
        int budget = 0;
        bit tog = 1'b1;
        bit v;
        exp_t e;
        threshold = MB'(thr0);
        while (i < n && budget < 2000) begin
            @(posedge clk); #1;
            if (i > 0) threshold = MB'(thr_mid);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            m_axis_tvalid = v;
            xi = DB'(fxi[i]); xq = DB'(fxq[i]); yi = DB'(fyi[i]); yq = DB'(fyq[i]);
            @(negedge clk);
            if (v && tready_c1) begin
                t_last = cyc;
                i++;
            end
            budget++;
        end
        if (i < n) begin
            n_chk++;
            $display("FAIL send_timeout: accepted %0d of %0d samples", i, n);
        end
        @(posedge clk); #1;
        m_axis_tvalid = 1'b0;
        if (n == LEN) begin
            model(1'b1, thr0, e.m1, e.i1, e.pi1, e.pq1, e.d1);
            model(1'b0, thr0, e.m0, e.i0, e.pi0, e.pq0, e.d0);
            e.vcyc = t_last + 6;
            expq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        while (expq.size() != 0 && b < 400) begin
            @(posedge clk);
            b++;
        end
        if (expq.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: %0d results still pending", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tvalid_c1 && hold_left > 0) begin
                m_axis_tready = 1'b0;
                hold_left--;
            end else begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (tvalid_c1 || tvalid_c0)) begin
            if (expq.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: result valid with nothing pending (t=%0t)",
                         $time);
            end else begin
                mon_e = expq[0];
                if (!seen) begin
                    chk("latency", cyc, mon_e.vcyc);
                    seen = 1'b1;
                end
                chk("tvalid_c1", tvalid_c1, 1);
                chk("tvalid_c0", tvalid_c0, 1);
                chk("tready_c1_in_output", tready_c1, 0);
                chk("tready_c0_in_output", tready_c0, 0);
                chk("out_max_c1", max_c1, mon_e.m1);
                chk("index_c1", idx_c1, mon_e.i1);
                chk("peak_i_c1", pi_c1, mon_e.pi1);
                chk("peak_q_c1", pq_c1, mon_e.pq1);
                chk("peak_detect_c1", det_c1, mon_e.d1);
                chk("out_max_c0", max_c0, mon_e.m0);
                chk("index_c0", idx_c0, mon_e.i0);
                chk("peak_i_c0", pi_c0, mon_e.pi0);
                chk("peak_q_c0", pq_c0, mon_e.pq0);
                chk("peak_detect_c0", det_c0, mon_e.d0);
                if (m_axis_tready) begin
                    void'(expq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        m_axis_tvalid = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        threshold = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_tready", tready_c1, 0);
        chk("rst_tvalid", tvalid_c1, 0);
        chk("rst_out_max", max_c1, 0);
        chk("rst_index", idx_c1, 0);
        chk("rst_peak_i", pi_c1, 0);
        chk("rst_peak_q", pq_c1, 0);
        chk("rst_detect", det_c1, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", tready_c1, 1);

        case_a();
        send_frame(0, 0, 0, LEN);
        wait_idle();

        fill(0, 100, 0, 100);
        send_frame(0, 0, 0, LEN);
        wait_idle();

        case_a();
        send_frame(400000001, 0, 0, LEN);
        wait_idle();

        case_a();
        hold_left = 10;
        send_frame(0, 0, 2, LEN);
        wait_idle();

        case_a();
        send_frame(0, 0, 1, LEN);
        wait_idle();

        // Aborted frame carries large magnitudes that must not leak into the next frame.
        fill(1000, 0, 1000, 0);
        send_frame(0, 0, 0, 3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midframe_rst_tready", tready_c1, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        fill(10, 0, 10, 0);
        fyi[2] = 30;
        fyi[6] = 20;
        send_frame(0, 0, 0, LEN);
        wait_idle();

        fill(-2048, -2048, -2048, -2048);
        send_frame(64'd70368744177664, 0, 0, LEN);
        wait_idle();

        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < LEN; k++) begin
                if (f % 3 == 0) begin
                    fxi[k] = int'($urandom_range(0, 2)) - 1;
                    fxq[k] = int'($urandom_range(0, 2)) - 1;
                    fyi[k] = int'($urandom_range(0, 2)) - 1;
                    fyq[k] = int'($urandom_range(0, 2)) - 1;
                end else begin
                    fxi[k] = int'($urandom_range(0, 4095)) - 2048;
                    fxq[k] = int'($urandom_range(0, 4095)) - 2048;
                    fyi[k] = int'($urandom_range(0, 4095)) - 2048;
                    fyq[k] = int'($urandom_range(0, 4095)) - 2048;
                end
            end
            send_frame(longint'($urandom) << ($urandom_range(0, 15)), longint'($urandom),
                       int'($urandom_range(0, 2)), LEN);
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/x_corr_peak.md
Name: x_corr_peak

Overview:
Parametrised successor to the streaming cross-correlation block. Per frame of `length` complex sample pairs (x, y) it forms the complex product x·y or x·conj(y), computes |p|² exactly, and tracks the running maximum. At frame end it presents index, magnitude, complex value and a threshold-detect flag on one output beat. It sits between the sample front end and the CAF peak search.

Parameters:
data_bits, 12, width of each of xi, xq, yi, yq (signed)
length, 16, samples per frame (>=2)
index_bits, 4, index width; must satisfy 2^index_bits >= length
conj_y, 1, 1: product is x·conj(y); 0: product is x·y
prod_bits, 2*data_bits+1, width of product I/Q (derived, do not override)
mag_bits, 2*prod_bits, width of |p|² (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
xi, xq, yi, yq  in  data_bits each  signed sample pair
m_axis_tvalid  in  1  upstream sample valid
s_axis_tready  out  1  block accepts a sample this cycle
threshold  in  mag_bits  unsigned detect threshold, sampled with frame sample 0
m_axis_tready  in  1  downstream ready for result
s_axis_tvalid  out  1  result valid
out_max  out  mag_bits  peak |p|²
index  out  index_bits  sample position of peak within frame
peak_i, peak_q  out  prod_bits each  signed product at peak
peak_detect  out  1  out_max >= latched threshold

Behaviour:
- Reset (sync, active-high): s_axis_tready=0 in the reset cycle, then 1 on the next cycle. s_axis_tvalid, out_max, index, peak_i, peak_q, peak_detect = 0. Sample counter, pipeline valids and running max cleared. Reset mid-frame or mid-handoff discards all partial state.
- Accept: a sample is taken when m_axis_tvalid && s_axis_tready.
- FSM states:
  - COLLECT: s_axis_tready=1. Counter increments per accepted sample. The accept of sample length-1 goes to DRAIN.
  - DRAIN: s_axis_tready=0. Waits until the last pipeline stage has been compared, then goes to OUTPUT.
  - OUTPUT: s_axis_tvalid=1 and outputs held stable. On m_axis_tready: clear s_axis_tvalid and the max, reset the counter, go to COLLECT.
- Pipeline, 5 stages, valid bit travels with the sample index:
  - S1: register inputs.
  - S2: four signed products.
  - S3: pi = xi·yi ± xq·yq, pq = xq·yi ∓ xi·yq (signs per conj_y), prod_bits wide, no overflow.
  - S4: pi², pq².
  - S5: mag = sum, mag_bits, unsigned.
- Compare stage:
  - Sample 0 always loads the max.
  - Later samples replace it only if strictly greater, so ties keep the lowest index.
- Latency: the last sample accepted at cycle t gives s_axis_tvalid=1 at t+6 when the pipeline was otherwise idle.
- Gaps in m_axis_tvalid are legal. Bubbles propagate and are never compared.
- peak_detect is registered at the OUTPUT entry from the final max and the threshold latched at frame start. threshold changes mid-frame are ignored.
- Extreme input: -2^(data_bits-1) on all inputs is legal and must not wrap.

Decomposition:
- Shared package: the derived width functions (prod_bits, mag_bits), the clog2 helper, and the FSM state encoding localparams.
- One natural sub-module: cmplx_mag_pipe. It contains S1–S5 with the valid/index sideband. It is reusable by the CAF block.

Test Plan (length=8, data_bits=12, conj_y=1 unless stated):
- x=(100,0) for all 8 samples; y=(100,0), except sample 5 where y=(200,0); threshold=0 -> index=5, out_max=400000000, peak_i=20000, peak_q=0, peak_detect=1, s_axis_tvalid 6 cycles after last accept.
- x=(0,100), y=(0,100) for all samples -> ties resolve to index=0, peak_i=10000, peak_q=0. Rerun with conj_y=0 -> peak_i=-10000.
- Repeat the first case with threshold=400000001 -> peak_detect=0. Change threshold to 0 mid-frame -> still 0.
- Hold m_axis_tready=0 for 10 cycles in OUTPUT -> outputs stable and s_axis_tready=0 throughout. Handoff, then the next frame indexes from 0.
- m_axis_tvalid toggling 1/0 every cycle -> same index/out_max as the gap-free run.
- Assert reset after 3 samples accepted, then feed a full frame with its peak at sample 2 -> index=2, and no residue from the aborted frame.
- All inputs -2048 -> out_max = (2·2048²)² = 70368744177664, no overflow.
